// File: rtl/rv32i_multicycle_sequencer.sv
// rv32i_multicycle_sequencer: multicycle RV32I control FSM with memory handshakes, branch resolve and trap
module rv32i_multicycle_sequencer #(
  parameter int          TIMEOUT_W = 8,
  parameter bit          WB_MERGE  = 1'b1,
  parameter logic [31:0] RESET_IR  = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        EQ,
  input  logic        LS,
  input  logic        LU,
  output logic [31:0] ir,
  output logic        addr_sel,
  output logic        pc_next_sel,
  output logic        sub_sra,
  output logic        pc_alu_sel,
  output logic        rd_we,
  output logic        pc_we,
  output logic        trap,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((2**TIMEOUT_W) - 2);
  state_t st, st_n;
  logic [TIMEOUT_W-1:0] cnt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic is_load, is_store, is_branch, is_op, is_opimm, is_lui, is_auipc, is_jal, is_jalr;
  logic legal, writes_rd, cmp, stall, tout;
  state_t nxt;
  assign opc       = ir[6:0];
  assign f3        = ir[14:12];
  assign is_load   = opc == 7'h03;
  assign is_opimm  = opc == 7'h13;
  assign is_store  = opc == 7'h23;
  assign is_op     = opc == 7'h33;
  assign is_branch = opc == 7'h63;
  assign is_auipc  = opc == 7'h17;
  assign is_lui    = opc == 7'h37;
  assign is_jalr   = opc == 7'h67;
  assign is_jal    = opc == 7'h6F;
  assign legal = (is_load | is_opimm | is_store | is_op | is_auipc | is_lui | is_jalr | is_jal)
               | (is_branch & (f3[2:1] != 2'b01));
  assign writes_rd = (is_load | is_opimm | is_op | is_lui | is_auipc | is_jal | is_jalr) & (ir[11:7] != 5'd0);
  // funct3[0] inverts the sense of each comparator pair (beq/bne, blt/bge, bltu/bgeu)
  assign cmp = (f3[2:1] == 2'b00 ? EQ : f3[2:1] == 2'b10 ? LS : LU) ^ f3[0];
  assign addr_sel    = is_jalr;
  assign pc_alu_sel  = is_auipc;
  assign pc_next_sel = is_jal | is_jalr | (is_branch & cmp);
  assign sub_sra     = is_op ? ir[30] : is_opimm ? ir[30] & (f3 == 3'b101) : is_branch;
  assign imem_req = st == FETCH;
  assign dmem_req = st == MEM;
  assign dmem_we  = dmem_req & is_store;
  assign trap     = st == TRAP;
  assign state    = st;
  assign stall = (imem_req & ~imem_ack) | (dmem_req & ~dmem_ack);
  assign tout  = stall & (cnt == TO_LAST);
  // run is only looked at on the way back to an instruction boundary
  assign nxt = run ? FETCH : IDLE;
  always_comb begin
    st_n  = st;
    rd_we = 1'b0;
    pc_we = 1'b0;
    case (st)
      IDLE:   st_n = run ? FETCH : IDLE;
      FETCH:  st_n = imem_ack ? DECODE : tout ? TRAP : FETCH;
      DECODE: st_n = legal ? EXEC : TRAP;
      EXEC: begin
        if (is_load | is_store) st_n = MEM;
        else if (WB_MERGE) begin
          rd_we = writes_rd;
          pc_we = 1'b1;
          st_n  = nxt;
        end else st_n = WB;
      end
      MEM: begin
        pc_we = dmem_ack & is_store;
        st_n  = dmem_ack ? (is_store ? nxt : WB) : tout ? TRAP : MEM;
      end
      WB: begin
        rd_we = writes_rd;
        pc_we = 1'b1;
        st_n  = nxt;
      end
      default: st_n = TRAP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= IDLE;
      ir  <= RESET_IR;
      cnt <= '0;
    end else begin
      st  <= st_n;
      ir  <= (imem_req & imem_ack) ? imem_rdata : ir;
      cnt <= (st_n != st) ? '0 : stall ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_rv32i_multicycle_sequencer.sv
// tb_rv32i_multicycle_sequencer: scoreboard bench; expected per-instruction retire summaries are queued then compared
module tb_rv32i_multicycle_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, EQ = 1'b0, LS = 1'b0, LU = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, dmem_req, dmem_we, addr_sel, pc_next_sel, sub_sra, pc_alu_sel, rd_we, pc_we, trap;
  logic [31:0] ir;
  logic [2:0]  state;
  int n_checks = 0, n_fail = 0;

  typedef struct packed {
    logic [7:0] cycles;
    logic [3:0] ireq, dreq, dwe, rd_cnt;
    logic [2:0] rd_st;
    logic [3:0] pc_cnt;
    logic [2:0] pc_st;
    logic       nsel, ssra, asel, pasel, trapped, req_at_trap;
  } res_t;
  res_t sb[$];

  rv32i_multicycle_sequencer #(.TIMEOUT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .EQ(EQ), .LS(LS), .LU(LU), .ir(ir),
    .addr_sel(addr_sel), .pc_next_sel(pc_next_sel), .sub_sra(sub_sra), .pc_alu_sel(pc_alu_sel),
    .rd_we(rd_we), .pc_we(pc_we), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  function automatic res_t mk(input int c, ic, dr, dw, rc, rs, pc, ps, input logic ns, ss, as, pa, tr);
    mk = '0;
    mk.cycles = 8'(c); mk.ireq = 4'(ic); mk.dreq = 4'(dr); mk.dwe = 4'(dw);
    mk.rd_cnt = 4'(rc); mk.rd_st = 3'(rs); mk.pc_cnt = 4'(pc); mk.pc_st = 3'(ps);
    mk.nsel = ns; mk.ssra = ss; mk.asel = as; mk.pasel = pa; mk.trapped = tr;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; EQ = 1'b0; LS = 1'b0; LU = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one instruction through fetch/memory handshakes and summarises what the DUT did until retire or trap.
  // A wait of -1 never acks.
  task automatic run_insn(input logic [31:0] instr, input int iwait, dwait, input logic [2:0] flags,
                          input bit drop_run, output res_t o);
    int fk = 0, dk = 0, n = 0;
    bit done = 0;
    o = '0;
    {EQ, LS, LU} = flags;
    while (!done && n < 60) begin
      @(negedge clk);
      imem_ack   = (state == 3'd1) && (fk == iwait);
      imem_rdata = instr;
      dmem_ack   = (state == 3'd4) && (dk == dwait);
      if (drop_run && state == 3'd2) run = 1'b0;
      #1;
      n++;
      if (state == 3'd0 && o.cycles == 0) continue;
      o.cycles++;
      if (imem_req) begin o.ireq++; fk++; end
      if (dmem_req) begin o.dreq++; dk++; if (dmem_we) o.dwe++; end
      if (rd_we) begin o.rd_cnt++; o.rd_st = state; end
      if (pc_we) begin
        o.pc_cnt++; o.pc_st = state; o.nsel = pc_next_sel; o.ssra = sub_sra;
        o.asel = addr_sel; o.pasel = pc_alu_sel; done = 1;
      end
      if (trap) begin o.trapped = 1'b1; o.req_at_trap = imem_req | dmem_req; done = 1; end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL retire_wait: insn %h did not retire or trap within 60 cycles, state=%0d", instr, state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({state, imem_req, dmem_req, dmem_we, rd_we, pc_we, trap, addr_sel, pc_next_sel, sub_sra, pc_alu_sel} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0d req=%b%b we=%b rd_we=%b pc_we=%b trap=%b sel=%b%b%b%b, required all 0",
               state, imem_req, dmem_req, dmem_we, rd_we, pc_we, trap, addr_sel, pc_next_sel, sub_sra, pc_alu_sel);
    end
    n_checks++;
    if (ir !== 32'h00000013) begin n_fail++; $display("FAIL reset_ir: got %h required 00000013", ir); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(3, 1, 0, 0, 1, 3, 1, 3, 0, 0, 0, 0, 0));
      run_insn(32'h00500093, 0, 0, 3'b000, 0, o);
      e = sb.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL addi_merge[%0d]: got %h required %h", i, o, e); end
    end
  endtask

  task automatic test_load_store();
    res_t o, e;
    sb.push_back(mk(10, 3, 4, 0, 1, 5, 1, 5, 0, 0, 0, 0, 0));
    run_insn(32'h0000A103, 2, 3, 3'b000, 0, o);
    e = sb.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL lw_waits: got %h required %h", o, e); end
    sb.push_back(mk(5, 1, 2, 2, 0, 0, 1, 4, 0, 0, 0, 0, 0));
    run_insn(32'h0020A023, 0, 1, 3'b000, 0, o);
    e = sb.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL sw_store: got %h required %h", o, e); end
  endtask

  logic [31:0] br_ins [5] = '{32'h00208063, 32'h00209063, 32'h0020C063, 32'h0020F063, 32'h0020E063};
  logic [2:0]  br_cmp [5] = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b000};
  logic        br_tk  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic test_branch();
    res_t o, e;
    for (int i = 0; i < 5; i++) sb.push_back(mk(3, 1, 0, 0, 0, 0, 1, 3, br_tk[i], 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      run_insn(br_ins[i], 0, 0, br_cmp[i], 0, o);
      e = sb.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL branch[%0d] %h: got %h required %h", i, br_ins[i], o, e); end
    end
  endtask

  logic [31:0] alu_ins [7] = '{32'h402081B3, 32'h4010D093, 32'hC0008093, 32'h008000EF,
                               32'h000100E7, 32'h00001297, 32'h00001037};

  task automatic test_alu_jump();
    res_t o, e;
    sb.push_back(mk(3, 1, 0, 0, 1, 3, 1, 3, 0, 1, 0, 0, 0));
    sb.push_back(mk(3, 1, 0, 0, 1, 3, 1, 3, 0, 1, 0, 0, 0));
    sb.push_back(mk(3, 1, 0, 0, 1, 3, 1, 3, 0, 0, 0, 0, 0));
    sb.push_back(mk(3, 1, 0, 0, 1, 3, 1, 3, 1, 0, 0, 0, 0));
    sb.push_back(mk(3, 1, 0, 0, 1, 3, 1, 3, 1, 0, 1, 0, 0));
    sb.push_back(mk(3, 1, 0, 0, 1, 3, 1, 3, 0, 0, 0, 1, 0));
    sb.push_back(mk(3, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++) begin
      run_insn(alu_ins[i], 0, 0, 3'b111, 0, o);
      e = sb.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL alu_jump[%0d] %h: got %h required %h", i, alu_ins[i], o, e); end
    end
  endtask

  task automatic test_illegal();
    res_t o, e;
    do_reset();
    run = 1'b1;
    sb.push_back(mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    run_insn(32'h0000007F, 0, 0, 3'b000, 0, o);
    e = sb.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL illegal_opcode: got %h required %h", o, e); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      imem_ack = 1'b1; dmem_ack = 1'b1; run = 1'b1;
      #1;
      n_checks++;
      if ({state, trap, imem_req, dmem_req, rd_we, pc_we} !== {3'd6, 5'b10000}) begin
        n_fail++;
        $display("FAIL trap_hold[%0d]: state=%0d trap=%b req=%b%b rd_we=%b pc_we=%b, required state=6 trap=1 rest 0",
                 i, state, trap, imem_req, dmem_req, rd_we, pc_we);
      end
    end
    do_reset();
    #1;
    n_checks++;
    if ({state, trap, ir} !== {3'd0, 1'b0, 32'h00000013}) begin
      n_fail++; $display("FAIL trap_cleared: state=%0d trap=%b ir=%h, required 0 0 00000013", state, trap, ir);
    end
    run = 1'b1;
    sb.push_back(mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    run_insn(32'h0020A063, 0, 0, 3'b000, 0, o);
    e = sb.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL illegal_branch_f3: got %h required %h", o, e); end
    do_reset();
    run = 1'b1;
    sb.push_back(mk(3, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0));
    run_insn(32'h00100013, 0, 0, 3'b000, 0, o);
    e = sb.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL addi_x0: got %h required %h", o, e); end
  endtask

  task automatic test_timeout();
    res_t o, e;
    do_reset();
    run = 1'b1;
    sb.push_back(mk(11, 1, 7, 0, 1, 5, 1, 5, 0, 0, 0, 0, 0));
    run_insn(32'h0000A103, 0, 6, 3'b000, 0, o);
    e = sb.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL ack_on_last_cycle: got %h required %h", o, e); end
    sb.push_back(mk(11, 1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    run_insn(32'h0020A023, 0, -1, 3'b000, 0, o);
    e = sb.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL dmem_timeout: got %h required %h", o, e); end
    do_reset();
    run = 1'b1;
    sb.push_back(mk(8, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    run_insn(32'h00500093, -1, 0, 3'b000, 0, o);
    e = sb.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL imem_timeout: got %h required %h", o, e); end
  endtask

  task automatic test_run_gate();
    res_t o, e;
    do_reset();
    run = 1'b1;
    sb.push_back(mk(3, 1, 0, 0, 1, 3, 1, 3, 0, 0, 0, 0, 0));
    run_insn(32'h00500093, 0, 0, 3'b000, 1, o);
    e = sb.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL run_drop_insn: got %h required %h", o, e); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem_ack = 1'b1;
      #1;
      n_checks++;
      if ({state, imem_req} !== 4'd0) begin
        n_fail++; $display("FAIL run_gate_idle[%0d]: state=%0d imem_req=%b, required 0 0", i, state, imem_req);
      end
    end
    imem_ack = 1'b0;
    run = 1'b1;
    sb.push_back(mk(3, 1, 0, 0, 1, 3, 1, 3, 0, 0, 0, 0, 0));
    run_insn(32'h00500093, 0, 0, 3'b000, 0, o);
    e = sb.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL run_resume: got %h required %h", o, e); end
  endtask

  task automatic test_reset_mid_mem();
    bit hit = 0;
    do_reset();
    run = 1'b1;
    imem_rdata = 32'h0000A103;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      imem_ack = (state == 3'd1);
      dmem_ack = 1'b0;
      #1;
      hit = (state == 3'd4);
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL reach_mem: state=%0d after 20 cycles, required 4", state); end
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({state, dmem_req, ir} !== {3'd0, 1'b0, 32'h00000013}) begin
      n_fail++; $display("FAIL mid_mem_reset: state=%0d dmem_req=%b ir=%h, required 0 0 00000013", state, dmem_req, ir);
    end
    dmem_ack = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({state, dmem_req, rd_we, pc_we, trap} !== 7'd0) begin
      n_fail++;
      $display("FAIL late_ack_ignored: state=%0d dmem_req=%b rd_we=%b pc_we=%b trap=%b, required all 0",
               state, dmem_req, rd_we, pc_we, trap);
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_store();
    test_branch();
    test_alu_jump();
    test_illegal();
    test_timeout();
    test_run_gate();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
